// File: rtl/serial_subtractor_pkg.sv
// serial_sub_pkg: shared state type and sizing helpers for serial_subtractor.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow output).
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEF = 8;

    // Bit-counter width for a given operand width.
    function automatic int sub_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_sub_if: start/done handshake and operand/result bus.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf signal.
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
`endif

endinterface

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: 1-bit combinational borrow cell.
// Shared by every bit position of serial_subtractor.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow output).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);

    localparam int              CW   = sub_cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             d;
    logic             bout;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d),
        .bout (bout)
    );

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // Operand MSBs captured at launch; overflow registered at completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state != RUN && bus.start) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == RUN && cnt == LAST) begin
            ovf_q <= (a_msb != b_msb) && (d != a_msb);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // Control FSM plus serial datapath: load, shift one bit per cycle, publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            brw      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        cnt    <= '0;
                        brw    <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    brw    <= bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_q   <= {d, res_sr[WIDTH-1:1]};
                        borrow_q <= bout;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor, WIDTH=8.
// Optional feature macro: SERIAL_SUB_OVF_EN enables the ovf checks.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] m_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int r;
        r = int'(a) - int'(b);
        return W'(r);
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return int'(a) < int'(b);
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        int r;
        sa = a[W-1] ? int'(a) - 256 : int'(a);
        sb = b[W-1] ? int'(b) - 256 : int'(b);
        r  = sa - sb;
        return (r > 127) || (r < -128);
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Launch one operation and wait (bounded) for done; no checking here.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busyc,
                          output logic busy_at_done);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat   = 0;
        busyc = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busyc++;
            @(negedge clk);
            lat++;
        end
        busy_at_done = bus.busy;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd3;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow, get_ovf()} !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow, get_ovf());
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b);
        int   lat;
        int   busyc;
        logic bd;
        run_op(a, b, lat, busyc, bd);
        checks++;
        if (lat !== W || bd !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency: lat=%0d busy=%b want %0d 0", nm, lat, bd, W);
        end
        checks++;
        if (bus.diff !== m_diff(a, b) || bus.borrow !== m_borrow(a, b)) begin
            errors++;
            $display("FAIL %s_result: a=%0d b=%0d diff=%h borrow=%b want %h %b",
                     nm, a, b, bus.diff, bus.borrow, m_diff(a, b), m_borrow(a, b));
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (bus.ovf !== m_ovf(a, b)) begin
            errors++;
            $display("FAIL %s_ovf: a=%h b=%h ovf=%b want %b", nm, a, b, bus.ovf, m_ovf(a, b));
        end
`endif
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b want 0", nm, bus.done);
        end
    endtask

    task automatic test_basic();
        int   lat;
        int   busyc;
        logic bd;
        run_op(8'd200, 8'd55, lat, busyc, bd);
        checks++;
        if (busyc !== W) begin
            errors++;
            $display("FAIL basic_busy_cycles: got=%0d want %0d", busyc, W);
        end
        checks++;
        if (lat !== W || bus.diff !== 8'd145 || bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL basic_200_55: lat=%0d diff=%0d borrow=%b want %0d 145 0",
                     lat, bus.diff, bus.borrow, W);
        end
        check_op("neg", 8'd5, 8'd9);
        check_op("zero", 8'd0, 8'd0);
        check_op("eq", 8'hA5, 8'hA5);
        check_op("wrap", 8'h00, 8'hFF);
    endtask

    task automatic test_ovf();
        check_op("ovf_80_01", 8'h80, 8'h01);
        check_op("ovf_7f_ff", 8'h7F, 8'hFF);
        check_op("ovf_7f_80", 8'h7F, 8'h80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_op("rand", W'($urandom), W'($urandom));
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd3;
        bus.b     = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                dones++;
                checks++;
                if (bus.diff !== 8'd2 || bus.borrow !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_result: diff=%0d borrow=%b want 2 0",
                             bus.diff, bus.borrow);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got=%0d want 1", dones);
        end
    endtask

    task automatic test_reset_midrun();
        int dones;
        int   lat;
        int   busyc;
        logic bd;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd77;
        bus.b     = 8'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow, get_ovf()} !== 12'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow, get_ovf());
        end
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got=%0d want 0", dones);
        end
        run_op(8'd10, 8'd4, lat, busyc, bd);
        checks++;
        if (lat !== W || bus.diff !== 8'd6 || bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL midrun_after: lat=%0d diff=%0d borrow=%b want %0d 6 0",
                     lat, bus.diff, bus.borrow, W);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   busyc;
        logic bd;
        int   gap;
        run_op(8'd7, 8'd3, lat, busyc, bd);
        checks++;
        if (lat !== W || bus.diff !== 8'd4) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d diff=%0d want %0d 4", lat, bus.diff, W);
        end
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        gap = 1;
        checks++;
        if (bus.diff !== 8'd4 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: diff=%0d done=%b busy=%b want 4 0 1",
                     bus.diff, bus.done, bus.busy);
        end
        while (!bus.done && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (gap !== W + 1 || bus.diff !== 8'hFF || bus.borrow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: gap=%0d diff=%h borrow=%b want %0d ff 1",
                     gap, bus.diff, bus.borrow, W + 1);
        end
        @(negedge clk);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_basic();
        test_ovf();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
